control_sequencer: RTL and testbench
====================================

# control_sequencer

Instruction sequencer that drives the microcode control memory of the 4-bit CPU. It fetches 8-bit instructions from program memory over a request/acknowledge handshake and latches them into an instruction register. It steps the 2-bit micro-phase counter `cnt` through four phases per instruction, presents `op`/`cnt` to the control memory, and consumes the returned jump field `f[15:14]` to update the program counter. It sits between program memory and the control memory/datapath.

## Interface
- `RESET_PC`, 8'h00, program counter value loaded on reset.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  8  fetch address; equals `pc`.
- `imem_ack`  in  1  program memory acknowledge; `imem_data` is valid in the same cycle.
- `imem_data`  in  8  instruction: [7:4] opcode, [3:0] operand n.
- `op`  out  4  latched opcode, to control memory.
- `cnt`  out  2  micro-phase, to control memory.
- `operand`  out  4  latched operand n, to datapath.
- `f_jmp`  in  2  `f[15:14]` from control memory: 00 none, 11 unconditional, 01 if zero, 10 if carry.
- `acc`  in  4  accumulator value from datapath.
- `zero_flag`  in  1  datapath zero flag.
- `carry_flag`  in  1  datapath carry flag.
- `hold`  in  1  freeze micro-phase (I/O port wait).
- `exec_valid`  out  1  high while in EXEC; qualifies `op`/`cnt`.
- `instr_done`  out  1  one-cycle pulse on the final phase of each instruction.
- `pc`  out  8  current program counter.

## Operation
- States: RESET_WAIT, FETCH, EXEC.
- RESET_WAIT: entered on reset and held for one cycle after reset deasserts, then goes to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. On `imem_ack`=1, capture `op`=`imem_data[7:4]` and `operand`=`imem_data[3:0]`, set `cnt`=0, and go to EXEC. Without ack, stay in FETCH with the request held and the address stable.
- EXEC: `exec_valid`=1.
  - If `hold`=0, `cnt` increments each cycle (0→1→2→3). If `hold`=1, `cnt`, `op` and `operand` are frozen.
  - At `cnt`=1 with `hold`=0, sample `f_jmp` and evaluate the condition using the `zero_flag`/`carry_flag` values in that cycle. Register `jump_taken` and `target = {operand,4'b0} + {4'b0,acc}` (8-bit, modulo 256).
  - At `cnt`=3 with `hold`=0: pulse `instr_done`. Set `pc` to `target` if `jump_taken`, else `pc+1` (8'hFF wraps to 8'h00). Clear `jump_taken` and go to FETCH.
- `f_jmp` is ignored in phases 0, 2 and 3.
- `hold` is ignored outside EXEC.

## Timing
- Reset values: `pc`=`RESET_PC`, `op`=0, `operand`=0, `cnt`=0, `imem_req`=0, `exec_valid`=0, `instr_done`=0, `jump_taken`=0, state RESET_WAIT. `imem_addr` follows `pc`.
- Reset asserted mid-instruction or mid-fetch: all state returns to reset values immediately and asynchronously. A pending ack is discarded.
- All outputs are registered except `imem_addr`, which is a wire of `pc`.
- With zero-wait memory (ack in the first FETCH cycle), an instruction takes 5 cycles: 1 FETCH + 4 EXEC. Each memory wait cycle adds 1 cycle. Each `hold` cycle adds 1 cycle.
- First `imem_req` rises on the 2nd rising edge after `rst` deasserts.
- `instr_done` and the `pc` update occur on the same edge that leaves `cnt`=3.
- `imem_req` falls on the edge that samples `imem_ack`=1.
- `exec_valid` rises on that same edge.

## Test plan
- Reset/fetch: `RESET_PC`=8'h10, zero-wait memory returning 8'h15 → `imem_addr`=8'h10 on the first request; `op`=1, `operand`=5, `cnt` sequence 0,1,2,3; `pc`=8'h11 after `instr_done`. Check 5-cycle period.
- Unconditional jump: instruction 8'h03, `acc`=4'h6, `f_jmp`=11 at `cnt`=1 → next `imem_addr`=8'h36.
- Conditional jumps:
  - 8'hC2 with `f_jmp`=01: `zero_flag`=1 → `pc`=8'h20+`acc`; `zero_flag`=0 → `pc+1`.
  - Repeat with 8'hD2, `f_jmp`=10 and `carry_flag`.
- Wrap: `pc`=8'hFF with a non-jump instruction → next fetch at 8'h00. Jump with operand F, `acc`=F → target 8'hFF.
- Stalls: ack delayed 3 cycles → `imem_req` held and address stable, then an 8-cycle instruction. `hold`=1 for 2 cycles at `cnt`=2 → `cnt` frozen, `instr_done` delayed 2 cycles.
- Reset mid-EXEC at `cnt`=2 → outputs at reset values asynchronously; after release, fetch restarts at `RESET_PC` and the interrupted instruction has no effect on `pc`.

Source files
------------

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Instruction sequencer for the 4-bit CPU. Fetches 8-bit instructions from
// program memory over a req/ack handshake, latches opcode/operand, steps the
// 2-bit micro-phase counter through four phases per instruction and applies
// the jump field returned by the control memory to the program counter.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   o_imem_req     fetch request, held until acknowledged
//   o_imem_addr    fetch address (combinational copy of o_pc)
//   i_imem_ack     program memory acknowledge, data valid same cycle
//   i_imem_data    instruction: [7:4] opcode, [3:0] operand
//   o_op           latched opcode to control memory
//   o_cnt          micro-phase to control memory
//   o_operand      latched operand to datapath
//   i_f_jmp        jump field: 00 none, 11 always, 01 if zero, 10 if carry
//   i_acc          accumulator from datapath (jump offset)
//   i_zero_flag    datapath zero flag
//   i_carry_flag   datapath carry flag
//   i_hold         freeze micro-phase while executing
//   o_exec_valid   high while executing, qualifies o_op/o_cnt
//   o_instr_done   one-cycle pulse as the last phase completes
//   o_pc           current program counter
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_imem_req,
  output logic [7:0] o_imem_addr,
  input  logic       i_imem_ack,
  input  logic [7:0] i_imem_data,
  output logic [3:0] o_op,
  output logic [1:0] o_cnt,
  output logic [3:0] o_operand,
  input  logic [1:0] i_f_jmp,
  input  logic [3:0] i_acc,
  input  logic       i_zero_flag,
  input  logic       i_carry_flag,
  input  logic       i_hold,
  output logic       o_exec_valid,
  output logic       o_instr_done,
  output logic [7:0] o_pc
);

  typedef enum logic [1:0] {
    StResetWait = 2'd0,
    StFetch     = 2'd1,
    StExec      = 2'd2
  } state_e;

  state_e     r_state;
  logic       r_wait_done;   // set after the first post-reset edge
  logic [7:0] r_pc;
  logic [3:0] r_op;
  logic [3:0] r_operand;
  logic [1:0] r_cnt;
  logic       r_imem_req;
  logic       r_exec_valid;
  logic       r_instr_done;
  logic       r_jump_taken;
  logic [7:0] r_target;

  logic       w_cond_met;
  logic [7:0] w_target;
  logic [7:0] w_pc_next;

  // Jump condition decode, only consumed in phase 1
  always_comb begin
    w_cond_met = 1'b0;
    case (i_f_jmp)
      2'b11:   w_cond_met = 1'b1;
      2'b01:   w_cond_met = i_zero_flag;
      2'b10:   w_cond_met = i_carry_flag;
      default: w_cond_met = 1'b0;
    endcase
  end

  // Target wraps modulo 256 by width truncation
  always_comb begin
    w_target  = {r_operand, 4'b0000} + {4'b0000, i_acc};
    w_pc_next = r_jump_taken ? r_target : (r_pc + 8'd1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StResetWait;
      r_wait_done  <= 1'b0;
      r_pc         <= RESET_PC;
      r_op         <= 4'h0;
      r_operand    <= 4'h0;
      r_cnt        <= 2'd0;
      r_imem_req   <= 1'b0;
      r_exec_valid <= 1'b0;
      r_instr_done <= 1'b0;
      r_jump_taken <= 1'b0;
      r_target     <= 8'h00;
    end else begin
      r_instr_done <= 1'b0;
      unique case (r_state)
        // One full idle cycle after reset release before the first request
        StResetWait: begin
          if (r_wait_done) begin
            r_state    <= StFetch;
            r_imem_req <= 1'b1;
          end else begin
            r_wait_done <= 1'b1;
          end
        end

        StFetch: begin
          if (i_imem_ack) begin
            r_op         <= i_imem_data[7:4];
            r_operand    <= i_imem_data[3:0];
            r_cnt        <= 2'd0;
            r_imem_req   <= 1'b0;
            r_exec_valid <= 1'b1;
            r_state      <= StExec;
          end
        end

        StExec: begin
          if (!i_hold) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd1) begin
              r_jump_taken <= w_cond_met;
              r_target     <= w_target;
            end
            if (r_cnt == 2'd3) begin
              r_instr_done <= 1'b1;
              r_pc         <= w_pc_next;
              r_jump_taken <= 1'b0;
              r_exec_valid <= 1'b0;
              r_imem_req   <= 1'b1;
              r_state      <= StFetch;
            end
          end
        end

        default: begin
          r_state <= StResetWait;
        end
      endcase
    end
  end

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_op         = r_op;
  assign o_cnt        = r_cnt;
  assign o_operand    = r_operand;
  assign o_exec_valid = r_exec_valid;
  assign o_instr_done = r_instr_done;
  assign o_pc         = r_pc;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clk;
  logic       i_rst_n;
  logic       o_imem_req;
  logic [7:0] o_imem_addr;
  logic       i_imem_ack;
  logic [7:0] i_imem_data;
  logic [3:0] o_op;
  logic [1:0] o_cnt;
  logic [3:0] o_operand;
  logic [1:0] i_f_jmp;
  logic [3:0] i_acc;
  logic       i_zero_flag;
  logic       i_carry_flag;
  logic       i_hold;
  logic       o_exec_valid;
  logic       o_instr_done;
  logic [7:0] o_pc;

  int checks;
  int errors;
  logic [7:0] m_pc;

  control_sequencer #(
    .RESET_PC(8'h10)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .i_imem_ack  (i_imem_ack),
    .i_imem_data (i_imem_data),
    .o_op        (o_op),
    .o_cnt       (o_cnt),
    .o_operand   (o_operand),
    .i_f_jmp     (i_f_jmp),
    .i_acc       (i_acc),
    .i_zero_flag (i_zero_flag),
    .i_carry_flag(i_carry_flag),
    .i_hold      (i_hold),
    .o_exec_valid(o_exec_valid),
    .o_instr_done(o_instr_done),
    .o_pc        (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  // Reference: next pc from the architectural rules
  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [7:0] instr,
                                            input logic [1:0] fj, input logic z,
                                            input logic c, input logic [3:0] a);
    bit take;
    int t;
    int n;
    take = (fj == 2'b11) || (fj == 2'b01 && z) || (fj == 2'b10 && c);
    t = (int'(instr[3:0]) * 16 + int'(a)) % 256;
    n = (int'(pc) + 1) % 256;
    return take ? 8'(t) : 8'(n);
  endfunction

  task automatic noise();
    i_f_jmp      = 2'($urandom);
    i_acc        = 4'($urandom);
    i_zero_flag  = 1'($urandom);
    i_carry_flag = 1'($urandom);
  endtask

  // Plays program memory and control memory for one instruction; records observations
  task automatic run_instr(
    input  logic [7:0] instr, input int ack_delay, input logic [1:0] fj,
    input  logic z, input logic c, input logic [3:0] a,
    input  int hold_phase, input int hold_len,
    output logic [7:0] req_addr, output logic addr_stable,
    output logic [3:0] obs_op, output logic [3:0] obs_operand,
    output logic seq_ok, output int cycles, output logic [7:0] pc_after);
    int ph;
    int holds_left;
    int guard;
    logic done;
    logic held;
    req_addr = 8'h00; addr_stable = 1'b1; obs_op = 4'h0; obs_operand = 4'h0;
    seq_ok = 1'b1; cycles = 0; pc_after = 8'h00;
    guard = 0;
    while (o_imem_req !== 1'b1 && guard < 20) begin
      i_imem_ack = 1'b0;
      noise();
      @(posedge clk); #1;
      guard++;
    end
    if (o_imem_req !== 1'b1) begin
      seq_ok = 1'b0;
      return;
    end
    req_addr = o_imem_addr;
    for (int k = 0; k < ack_delay; k++) begin
      i_imem_ack  = 1'b0;
      i_imem_data = 8'($urandom);
      i_hold      = 1'($urandom);
      noise();
      @(posedge clk); #1;
      cycles++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== req_addr || o_exec_valid !== 1'b0)
        addr_stable = 1'b0;
    end
    i_imem_ack  = 1'b1;
    i_imem_data = instr;
    i_hold      = 1'($urandom);
    noise();
    @(posedge clk); #1;
    cycles++;
    obs_op      = o_op;
    obs_operand = o_operand;
    if (o_imem_req !== 1'b0 || o_exec_valid !== 1'b1) seq_ok = 1'b0;
    ph = 0;
    holds_left = hold_len;
    done = 1'b0;
    for (int g = 0; g < 40 && !done; g++) begin
      if (o_cnt !== 2'(ph) || o_exec_valid !== 1'b1 || o_instr_done !== 1'b0) seq_ok = 1'b0;
      held = (ph == hold_phase) && (holds_left > 0);
      i_hold = held;
      if (ph == 1 && !held) begin
        i_f_jmp = fj; i_zero_flag = z; i_carry_flag = c; i_acc = a;
      end else begin
        noise();
      end
      i_imem_ack  = 1'($urandom);
      i_imem_data = 8'($urandom);
      @(posedge clk); #1;
      cycles++;
      if (held) holds_left--;
      else ph++;
      if (ph == 4) begin
        done = 1'b1;
        if (o_instr_done !== 1'b1 || o_exec_valid !== 1'b0 || o_imem_req !== 1'b1)
          seq_ok = 1'b0;
        pc_after = o_pc;
      end
    end
    if (!done) seq_ok = 1'b0;
    i_imem_ack = 1'b0;
    i_hold     = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_imem_req !== 1'b0 || o_exec_valid !== 1'b0 || o_instr_done !== 1'b0 ||
        o_pc !== 8'h10 || o_imem_addr !== 8'h10 || o_op !== 4'h0 || o_operand !== 4'h0 ||
        o_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: req=%b ev=%b done=%b pc=%h addr=%h op=%h opnd=%h cnt=%0d, required 0 0 0 10 10 0 0 0",
               o_imem_req, o_exec_valid, o_instr_done, o_pc, o_imem_addr, o_op, o_operand, o_cnt);
    end
    #3 i_rst_n = 1'b1;
    edges = 0;
    while (edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (o_imem_req === 1'b1) break;
    end
    checks++;
    if (edges != 2) begin
      errors++;
      $display("FAIL first_req_edge: req rose after %0d edges, required 2", edges);
    end
    checks++;
    if (o_imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL first_req_addr: got %h required 10", o_imem_addr);
    end
    m_pc = 8'h10;
  endtask

  task automatic test_fetch();
    logic [7:0] ra, pa, exp;
    logic st, ok;
    logic [3:0] op, opnd;
    int cyc;
    exp = model_next(m_pc, 8'h15, 2'b00, 1'b1, 1'b1, 4'hF);
    run_instr(8'h15, 0, 2'b00, 1'b1, 1'b1, 4'hF, -1, 0, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (ra !== 8'h10) begin errors++; $display("FAIL fetch_addr: got %h required 10", ra); end
    checks++;
    if (op !== 4'h1 || opnd !== 4'h5) begin
      errors++; $display("FAIL fetch_latch: op=%h operand=%h required 1 5", op, opnd);
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL fetch_sequence: got %b required 1", ok); end
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL fetch_period: got %0d required 5", cyc); end
    checks++;
    if (pa !== exp) begin errors++; $display("FAIL fetch_pc: got %h required %h", pa, exp); end
    m_pc = exp;
  endtask

  task automatic test_uncond_jump();
    logic [7:0] ra, pa, exp;
    logic st, ok;
    logic [3:0] op, opnd;
    int cyc;
    exp = model_next(m_pc, 8'h03, 2'b11, 1'b0, 1'b0, 4'h6);
    run_instr(8'h03, 0, 2'b11, 1'b0, 1'b0, 4'h6, -1, 0, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (pa !== exp || ok !== 1'b1) begin
      errors++; $display("FAIL uncond_jump_pc: got %h ok=%b required %h", pa, ok, exp);
    end
    checks++;
    if (o_imem_addr !== 8'h36 || o_imem_req !== 1'b1) begin
      errors++; $display("FAIL uncond_jump_addr: got %h req=%b required 36", o_imem_addr, o_imem_req);
    end
    m_pc = exp;
  endtask

  task automatic test_cond_jumps();
    logic [7:0] instrs [4] = '{8'hC2, 8'hC2, 8'hD2, 8'hD2};
    logic [1:0] fjs    [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic       flg    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ra, pa, exp;
      logic st, ok, z, c;
      logic [3:0] op, opnd, a;
      int cyc;
      a = 4'($urandom);
      z = (fjs[i] == 2'b01) ? flg[i] : 1'($urandom);
      c = (fjs[i] == 2'b10) ? flg[i] : 1'($urandom);
      exp = model_next(m_pc, instrs[i], fjs[i], z, c, a);
      run_instr(instrs[i], 0, fjs[i], z, c, a, -1, 0, ra, st, op, opnd, ok, cyc, pa);
      checks++;
      if (pa !== exp || ok !== 1'b1) begin
        errors++;
        $display("FAIL cond_jump[%0d]: got pc %h ok=%b required %h", i, pa, ok, exp);
      end
      m_pc = exp;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ra, pa;
    logic st, ok;
    logic [3:0] op, opnd;
    int cyc;
    run_instr(8'hAF, 0, 2'b11, 1'b0, 1'b0, 4'hF, -1, 0, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (pa !== 8'hFF) begin errors++; $display("FAIL wrap_target: got %h required ff", pa); end
    run_instr(8'h5A, 0, 2'b00, 1'b1, 1'b1, 4'h9, -1, 0, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (ra !== 8'hFF) begin errors++; $display("FAIL wrap_fetch_ff: got %h required ff", ra); end
    checks++;
    if (pa !== 8'h00 || o_imem_addr !== 8'h00) begin
      errors++; $display("FAIL wrap_pc: got %h addr %h required 00", pa, o_imem_addr);
    end
    m_pc = 8'h00;
  endtask

  task automatic test_stalls();
    logic [7:0] ra, pa, exp;
    logic st, ok;
    logic [3:0] op, opnd;
    int cyc;
    exp = model_next(m_pc, 8'h47, 2'b00, 1'b0, 1'b0, 4'h0);
    run_instr(8'h47, 3, 2'b00, 1'b0, 1'b0, 4'h0, -1, 0, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL ack_wait_stable: got %b required 1", st); end
    checks++;
    if (cyc != 8 || ok !== 1'b1 || pa !== exp) begin
      errors++; $display("FAIL ack_wait_instr: cycles %0d pc %h ok=%b required 8 %h 1", cyc, pa, ok, exp);
    end
    m_pc = exp;
    exp = model_next(m_pc, 8'h9B, 2'b00, 1'b0, 1'b0, 4'h0);
    run_instr(8'h9B, 0, 2'b00, 1'b0, 1'b0, 4'h0, 2, 2, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (cyc != 7 || ok !== 1'b1 || pa !== exp) begin
      errors++; $display("FAIL hold_instr: cycles %0d pc %h ok=%b required 7 %h 1", cyc, pa, ok, exp);
    end
    m_pc = exp;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra, pa, exp, instr;
      logic st, ok, z, c;
      logic [3:0] op, opnd, a;
      logic [1:0] fj;
      int cyc, ad, hp, hl;
      instr = 8'($urandom);
      fj = 2'($urandom);
      z = 1'($urandom);
      c = 1'($urandom);
      a = 4'($urandom);
      ad = $urandom_range(0, 3);
      hp = $urandom_range(0, 4);
      if (hp == 4) hp = -1;
      hl = (hp < 0) ? 0 : $urandom_range(0, 3);
      exp = model_next(m_pc, instr, fj, z, c, a);
      run_instr(instr, ad, fj, z, c, a, hp, hl, ra, st, op, opnd, ok, cyc, pa);
      checks++;
      if (ra !== m_pc || st !== 1'b1) begin
        errors++; $display("FAIL rand_fetch[%0d]: addr %h stable %b required %h 1", i, ra, st, m_pc);
      end
      checks++;
      if (op !== instr[7:4] || opnd !== instr[3:0]) begin
        errors++; $display("FAIL rand_latch[%0d]: got %h%h required %h", i, op, opnd, instr);
      end
      checks++;
      if (ok !== 1'b1 || cyc != 5 + ad + hl) begin
        errors++; $display("FAIL rand_timing[%0d]: ok=%b cycles %0d required 1 %0d", i, ok, cyc, 5 + ad + hl);
      end
      checks++;
      if (pa !== exp) begin
        errors++; $display("FAIL rand_pc[%0d]: got %h required %h", i, pa, exp);
      end
      m_pc = exp;
    end
  endtask

  task automatic test_reset_mid_exec();
    int guard, edges;
    logic [7:0] ra, pa;
    logic st, ok;
    logic [3:0] op, opnd;
    int cyc;
    guard = 0;
    while (o_imem_req !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    i_imem_ack = 1'b1; i_imem_data = 8'h37; i_hold = 1'b0;
    @(posedge clk); #1;
    i_imem_ack = 1'b0;
    @(posedge clk); #1;
    i_f_jmp = 2'b11; i_acc = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (o_cnt !== 2'd2 || o_exec_valid !== 1'b1) begin
      errors++; $display("FAIL midexec_setup: cnt %0d ev %b required 2 1", o_cnt, o_exec_valid);
    end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_imem_req !== 1'b0 || o_exec_valid !== 1'b0 || o_instr_done !== 1'b0 ||
        o_pc !== 8'h10 || o_op !== 4'h0 || o_operand !== 4'h0 || o_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: req=%b ev=%b pc=%h op=%h opnd=%h cnt=%0d required 0 0 10 0 0 0",
               o_imem_req, o_exec_valid, o_pc, o_op, o_operand, o_cnt);
    end
    i_imem_ack = 1'b1; i_imem_data = 8'hE9;
    @(posedge clk); #1;
    checks++;
    if (o_imem_req !== 1'b0 || o_exec_valid !== 1'b0 || o_op !== 4'h0) begin
      errors++; $display("FAIL reset_ack_ignored: req=%b ev=%b op=%h required 0 0 0",
                         o_imem_req, o_exec_valid, o_op);
    end
    i_imem_ack = 1'b0;
    #3 i_rst_n = 1'b1;
    edges = 0;
    while (edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (o_imem_req === 1'b1) break;
    end
    checks++;
    if (edges != 2 || o_imem_addr !== 8'h10) begin
      errors++; $display("FAIL restart_fetch: edges %0d addr %h required 2 10", edges, o_imem_addr);
    end
    m_pc = 8'h10;
    run_instr(8'h21, 0, 2'b00, 1'b0, 1'b0, 4'h0, -1, 0, ra, st, op, opnd, ok, cyc, pa);
    checks++;
    if (pa !== 8'h11 || ok !== 1'b1) begin
      errors++; $display("FAIL post_reset_instr: got %h ok=%b required 11 1", pa, ok);
    end
    m_pc = pa;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pc = 8'h10;
    i_rst_n = 1'b0;
    i_imem_ack = 1'b0;
    i_imem_data = 8'h00;
    i_f_jmp = 2'b00;
    i_acc = 4'h0;
    i_zero_flag = 1'b0;
    i_carry_flag = 1'b0;
    i_hold = 1'b0;
    test_reset();
    test_fetch();
    test_uncond_jump();
    test_cond_jumps();
    test_wrap();
    test_stalls();
    test_random();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
